// File: rtl/cursor_pos_ctrl.sv
// cursor_pos_ctrl
//   Turns five raw active-low push-buttons into signed cursor offsets for the
//   VGA sprite renderer. The position moves once per video frame, paced by the
//   rising edge of the renderer's vertical sync. Holding a direction makes the
//   cursor accelerate, and the position is clamped to the visible area.
//
// Ports
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_btn_up/down/left/right/center  raw buttons, active-low, asynchronous
//   i_vs                vertical sync from the VGA block, active-low, asynchronous
//   o_x_pos, o_y_pos    signed 10-bit offsets (positive Y = up)
//   o_frame_tick        one-cycle pulse marking each position update
//   o_moving            last update requested motion on either axis
module cursor_pos_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int X_MIN           = -295,
  parameter int X_MAX           = 340,
  parameter int Y_MIN           = -260,
  parameter int Y_MAX           = 215,
  parameter int STEP_MAX        = 4,
  parameter int ACCEL_FRAMES    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_btn_up,
  input  logic              i_btn_down,
  input  logic              i_btn_left,
  input  logic              i_btn_right,
  input  logic              i_btn_center,
  input  logic              i_vs,
  output logic signed [9:0] o_x_pos,
  output logic signed [9:0] o_y_pos,
  output logic              o_frame_tick,
  output logic              o_moving
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       ACCEL_8    = 8'(ACCEL_FRAMES);
  localparam logic [7:0]       STEP_MAX_8 = 8'(STEP_MAX);
  localparam logic [7:0]       HOLD_SAT   = 8'(ACCEL_FRAMES * STEP_MAX);
  localparam logic signed [11:0] X_MIN_12 = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_12 = 12'(X_MAX);
  localparam logic signed [11:0] Y_MIN_12 = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_12 = 12'(Y_MAX);

  // Clamp a widened sum into [lo, hi]; the bounds fit in 10 bits, so the
  // truncation after clamping is lossless.
  function automatic logic signed [9:0] clamp10(input logic signed [11:0] v,
                                                input logic signed [11:0] lo,
                                                input logic signed [11:0] hi);
    logic signed [11:0] c;
    if (v < lo)      c = lo;
    else if (v > hi) c = hi;
    else             c = v;
    return c[9:0];
  endfunction

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 centre, 5 vsync.
  logic [5:0] raw;
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;

  assign raw = {i_vs, i_btn_center, i_btn_right, i_btn_left, i_btn_down, i_btn_up};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: count while the sample disagrees with the accepted level,
  // accept it once it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  logic [4:0] level;

  for (genvar g = 0; g < 5; g++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else if (sync2_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level[g] = lvl_q;
  end

  // Frame tick: rising edge of the synchronised sync (end of the pulse).
  logic vs_prev_q;
  logic tick;
  assign tick = sync2_q[5] & ~vs_prev_q;

  // Recentre fires on the debounced press edge of the centre button only.
  logic cen_prev_q;
  logic recentre;
  assign recentre = cen_prev_q & ~level[4];

  // Opposing buttons cancel, so each axis moves only when exactly one is held.
  logic dx_pos, dx_neg, dy_pos, dy_neg, motion;
  assign dx_pos = ~level[3] &  level[2];
  assign dx_neg =  level[3] & ~level[2];
  assign dy_pos = ~level[0] &  level[1];
  assign dy_neg =  level[0] & ~level[1];
  assign motion = dx_pos | dx_neg | dy_pos | dy_neg;

  logic [7:0]         hold_q, hold_d;
  logic [7:0]         step_raw, step;
  logic signed [11:0] step_s;

  assign step_raw = (hold_q / ACCEL_8) + 8'd1;
  assign step     = (step_raw > STEP_MAX_8) ? STEP_MAX_8 : step_raw;
  assign step_s   = $signed({4'b0000, step});

  logic signed [9:0]  x_q, x_d, y_q, y_d;
  logic signed [11:0] x_sum, y_sum;
  logic               moving_q, moving_d;
  logic               tick_q;

  always_comb begin
    x_sum = $signed({{2{x_q[9]}}, x_q});
    if (dx_pos) x_sum = x_sum + step_s;
    if (dx_neg) x_sum = x_sum - step_s;
    y_sum = $signed({{2{y_q[9]}}, y_q});
    if (dy_pos) y_sum = y_sum + step_s;
    if (dy_neg) y_sum = y_sum - step_s;
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    hold_d   = hold_q;
    moving_d = moving_q;
    if (tick) begin
      x_d      = clamp10(x_sum, X_MIN_12, X_MAX_12);
      y_d      = clamp10(y_sum, Y_MIN_12, Y_MAX_12);
      moving_d = motion;
      if (!motion)               hold_d = 8'd0;
      else if (hold_q < HOLD_SAT) hold_d = hold_q + 8'd1;
    end
    // Recentre overrides a coincident tick's movement.
    if (recentre) begin
      x_d    = '0;
      y_d    = '0;
      hold_d = 8'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      hold_q     <= 8'd0;
      moving_q   <= 1'b0;
      tick_q     <= 1'b0;
      vs_prev_q  <= 1'b1;
      cen_prev_q <= 1'b1;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      hold_q     <= hold_d;
      moving_q   <= moving_d;
      tick_q     <= tick;
      vs_prev_q  <= sync2_q[5];
      cen_prev_q <= level[4];
    end
  end

  assign o_x_pos      = x_q;
  assign o_y_pos      = y_q;
  assign o_frame_tick = tick_q;
  assign o_moving     = moving_q;

endmodule
